st_resp_arbiter: RTL and testbench

- Merges response packets from NUM_REQ Avalon-ST sources into the single response stream to the host: the task parser plus one response port per task handler (BANK, OUT).
- Arbitration is packet-atomic round-robin: once a source is granted, its whole sop..eop packet passes before any other source is considered.
- Enforces a maximum packet length. An over-long packet is truncated with a forced eop and the rest of it is drained.

---
 rtl/icd_pkg.sv | 14 +
 rtl/st_resp_arbiter_rr_pick.sv | 38 +++
 rtl/st_resp_arbiter.sv | 166 ++++++++++++++++
 tb/tb_st_resp_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icd_pkg.sv
// Shared constants for the response path.
//   RESP_WORD_W     : width of one response-stream data word
//   MAX_RESP_WORDS  : default packet-length limit on the merged response stream
//   RESP_SRC_*      : fixed source indices on the response arbiter
package icd_pkg;

  localparam int unsigned RESP_WORD_W    = 32;
  localparam int unsigned MAX_RESP_WORDS = 16;

  localparam int unsigned RESP_SRC_PARSER = 0;
  localparam int unsigned RESP_SRC_BANK   = 1;
  localparam int unsigned RESP_SRC_OUT    = 2;

endpackage

// File: rtl/st_resp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i    : request vector, one bit per source
//   last_i   : index of the previous winner; search starts at last_i+1
//   onehot_o : one-hot winner (zero when no request)
//   idx_o    : winner index (zero when no request)
//   any_o    : at least one request present
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned j;
  logic        found;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    j        = 0;
    // Offsets 1..NUM_REQ visit every source once, ending on last_i itself.
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      j = (32'(last_i) + i) % NUM_REQ;
      if (!found && req_i[IDX_W'(j)]) begin
        found                 = 1'b1;
        onehot_o[IDX_W'(j)]   = 1'b1;
        idx_o                 = IDX_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/st_resp_arbiter.sv
// st_resp_arbiter: packet-atomic round-robin merge of NUM_REQ Avalon-ST
// response sources onto one host response stream, with max-length truncation.
//   clk, rst_n         : clock, synchronous active-low reset
//   asi_req_*          : per-source valid/sop/eop/data in, ready out
//   aso_resp_*         : merged output stream (combinational mux of owner)
//   grant              : one-hot current owner, zero when idle
//   err_orphan         : pulse, a sop-less word was dropped while idle
//   err_overlen        : pulse, a packet was truncated at MAX_PKT_WORDS
module st_resp_arbiter
  import icd_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 3,
  parameter int unsigned MAX_PKT_WORDS = MAX_RESP_WORDS
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             asi_req_valid,
  input  logic [NUM_REQ-1:0]             asi_req_sop,
  input  logic [NUM_REQ-1:0]             asi_req_eop,
  input  logic [RESP_WORD_W*NUM_REQ-1:0] asi_req_data,
  output logic [NUM_REQ-1:0]             asi_req_ready,
  input  logic                           aso_resp_ready,
  output logic                           aso_resp_valid,
  output logic                           aso_resp_sop,
  output logic                           aso_resp_eop,
  output logic [RESP_WORD_W-1:0]         aso_resp_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           err_orphan,
  output logic                           err_overlen
);

  localparam int unsigned IDX_W  = $clog2(NUM_REQ);
  localparam int unsigned WCNT_W = 6;

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} arb_state_e;

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [IDX_W-1:0]   last_q;
  logic [WCNT_W-1:0]  wcnt_q;
  logic               err_orphan_q;
  logic               err_overlen_q;

  logic [RESP_WORD_W-1:0] src_data [NUM_REQ];
  logic                   g_valid, g_sop, g_eop, at_max;
  logic [NUM_REQ-1:0]     cand, orphan;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      src_data[i] = asi_req_data[i*RESP_WORD_W +: RESP_WORD_W];
    end
  end

  assign g_valid = asi_req_valid[gidx_q];
  assign g_sop   = asi_req_sop[gidx_q];
  assign g_eop   = asi_req_eop[gidx_q];
  assign at_max  = (wcnt_q == WCNT_W'(MAX_PKT_WORDS - 1));
  assign cand    = asi_req_valid & asi_req_sop;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i    (cand),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // The state register only clears on the edge, so the handshake outputs are
  // also held off while rst_n is low to keep the in-flight packet from moving.
  always_comb begin
    asi_req_ready  = '0;
    aso_resp_valid = 1'b0;
    aso_resp_sop   = 1'b0;
    aso_resp_eop   = 1'b0;
    aso_resp_data  = '0;
    orphan         = '0;
    case (state_q)
      IDLE: begin
        orphan        = asi_req_valid & ~asi_req_sop;
        asi_req_ready = orphan;
      end
      PASS: begin
        aso_resp_valid        = g_valid;
        aso_resp_sop          = g_sop;
        aso_resp_eop          = g_eop | at_max;
        aso_resp_data         = src_data[gidx_q];
        asi_req_ready[gidx_q] = aso_resp_ready;
      end
      DRAIN: begin
        asi_req_ready[gidx_q] = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      asi_req_ready  = '0;
      aso_resp_valid = 1'b0;
      aso_resp_sop   = 1'b0;
      aso_resp_eop   = 1'b0;
      aso_resp_data  = '0;
      orphan         = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      wcnt_q        <= '0;
      err_orphan_q  <= 1'b0;
      err_overlen_q <= 1'b0;
    end else begin
      err_orphan_q  <= 1'b0;
      err_overlen_q <= 1'b0;
      case (state_q)
        IDLE: begin
          err_orphan_q <= |orphan;
          if (pick_any) begin
            grant_q <= pick_onehot;
            gidx_q  <= pick_idx;
            last_q  <= pick_idx;
            wcnt_q  <= '0;
            state_q <= PASS;
          end
        end
        PASS: begin
          if (g_valid && aso_resp_ready) begin
            // Natural eop wins over truncation when both land on the last word.
            if (g_eop) begin
              state_q <= IDLE;
              grant_q <= '0;
            end else if (at_max) begin
              state_q       <= DRAIN;
              err_overlen_q <= 1'b1;
            end else begin
              wcnt_q <= wcnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (g_valid && g_eop) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign err_orphan  = err_orphan_q;
  assign err_overlen = err_overlen_q;

endmodule

// File: tb/tb_st_resp_arbiter.sv
module tb_st_resp_arbiter;

  localparam int NR  = 3;
  localparam int MAX = 16;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } word_t;

  typedef struct {
    logic [NR-1:0] v;
    logic [NR-1:0] s;
    logic [NR-1:0] exp_rdy;
    logic [NR-1:0] exp_gnt;
    logic          exp_orph;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NR-1:0]    asi_req_valid = '0;
  logic [NR-1:0]    asi_req_sop = '0;
  logic [NR-1:0]    asi_req_eop = '0;
  logic [32*NR-1:0] asi_req_data = '0;
  logic [NR-1:0]    asi_req_ready;
  logic             aso_resp_ready = 1'b1;
  logic             aso_resp_valid;
  logic             aso_resp_sop;
  logic             aso_resp_eop;
  logic [31:0]      aso_resp_data;
  logic [NR-1:0]    grant;
  logic             err_orphan;
  logic             err_overlen;

  st_resp_arbiter #(
    .NUM_REQ       (NR),
    .MAX_PKT_WORDS (MAX)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .asi_req_valid  (asi_req_valid),
    .asi_req_sop    (asi_req_sop),
    .asi_req_eop    (asi_req_eop),
    .asi_req_data   (asi_req_data),
    .asi_req_ready  (asi_req_ready),
    .aso_resp_ready (aso_resp_ready),
    .aso_resp_valid (aso_resp_valid),
    .aso_resp_sop   (aso_resp_sop),
    .aso_resp_eop   (aso_resp_eop),
    .aso_resp_data  (aso_resp_data),
    .grant          (grant),
    .err_orphan     (err_orphan),
    .err_overlen    (err_overlen)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    ovl_cnt = 0;
  int    orph_cnt = 0;
  word_t srcq [NR][$];
  word_t expq [$];
  bit    rdyq [$];
  vec_t  vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit busy();
    bit b = (expq.size() != 0);
    for (int s = 0; s < NR; s++) if (srcq[s].size() != 0) b = 1'b1;
    return b;
  endfunction

  // One clock: drive source heads at negedge, sample at negedge+1.
  task automatic step(input bit rst_v = 1'b1);
    word_t e;
    @(negedge clk);
    rst_n = rst_v;
    for (int s = 0; s < NR; s++) begin
      if (srcq[s].size() != 0) begin
        asi_req_valid[s]        = 1'b1;
        asi_req_sop[s]          = srcq[s][0].sop;
        asi_req_eop[s]          = srcq[s][0].eop;
        asi_req_data[s*32 +: 32] = srcq[s][0].data;
      end else begin
        asi_req_valid[s]        = 1'b0;
        asi_req_sop[s]          = 1'b0;
        asi_req_eop[s]          = 1'b0;
        asi_req_data[s*32 +: 32] = '0;
      end
    end
    aso_resp_ready = (rdyq.size() != 0) ? rdyq.pop_front() : 1'b1;
    #1;
    chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
    if (grant != '0) chk("stall_others", 64'(asi_req_ready & ~grant), 64'd0);
    if (err_overlen) ovl_cnt++;
    if (err_orphan) orph_cnt++;
    if (aso_resp_valid && aso_resp_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_out: got %0h expected no output (t=%0t)", aso_resp_data, $time);
      end else begin
        e = expq.pop_front();
        chk("out_word", 64'({aso_resp_sop, aso_resp_eop, aso_resp_data}), 64'({e.sop, e.eop, e.data}));
      end
    end
    for (int s = 0; s < NR; s++)
      if (asi_req_valid[s] && asi_req_ready[s] && srcq[s].size() != 0) void'(srcq[s].pop_front());
  endtask

  task automatic run(input string name, input int budget, output int cyc);
    cyc = 0;
    while (busy() && cyc < budget) begin
      step();
      cyc++;
    end
    if (busy()) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending words expected 0", name, expq.size());
      expq.delete();
      for (int s = 0; s < NR; s++) srcq[s].delete();
    end
  endtask

  // Source packet of n words; expected output is truncated at MAX with forced eop.
  task automatic push_pkt(input int s, input int n, input logic [31:0] base);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.sop  = (i == 0);
      w.eop  = (i == n - 1);
      w.data = base + 32'(i);
      srcq[s].push_back(w);
      if (i < MAX) begin
        w.eop = (i == n - 1) || (i == MAX - 1);
        expq.push_back(w);
      end
    end
  endtask

  task automatic do_reset();
    expq.delete();
    rdyq.delete();
    for (int s = 0; s < NR; s++) srcq[s].delete();
    step(1'b0);
    step();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_out", 64'({aso_resp_valid, aso_resp_sop, aso_resp_eop, aso_resp_data}), 64'd0);
    chk("rst_ready", 64'(asi_req_ready), 64'd0);
    chk("rst_err", 64'({err_orphan, err_overlen}), 64'd0);
    ovl_cnt  = 0;
    orph_cnt = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    word_t w;

    // IDLE arbitration from reset (last = 2, so search order 0,1,2) and orphans.
    vt[0] = '{v: 3'b000, s: 3'b000, exp_rdy: 3'b000, exp_gnt: 3'b000, exp_orph: 1'b0};
    vt[1] = '{v: 3'b111, s: 3'b111, exp_rdy: 3'b000, exp_gnt: 3'b001, exp_orph: 1'b0};
    vt[2] = '{v: 3'b110, s: 3'b110, exp_rdy: 3'b000, exp_gnt: 3'b010, exp_orph: 1'b0};
    vt[3] = '{v: 3'b100, s: 3'b100, exp_rdy: 3'b000, exp_gnt: 3'b100, exp_orph: 1'b0};
    vt[4] = '{v: 3'b011, s: 3'b001, exp_rdy: 3'b010, exp_gnt: 3'b001, exp_orph: 1'b1};
    vt[5] = '{v: 3'b111, s: 3'b000, exp_rdy: 3'b111, exp_gnt: 3'b000, exp_orph: 1'b1};
    vt[6] = '{v: 3'b101, s: 3'b100, exp_rdy: 3'b001, exp_gnt: 3'b100, exp_orph: 1'b1};
    vt[7] = '{v: 3'b110, s: 3'b100, exp_rdy: 3'b010, exp_gnt: 3'b100, exp_orph: 1'b1};

    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      rst_n          = 1'b1;
      aso_resp_ready = 1'b1;
      asi_req_valid  = vt[k].v;
      asi_req_sop    = vt[k].s;
      asi_req_eop    = vt[k].v;
      asi_req_data   = {32'h0000_2222, 32'h0000_1111, 32'h0000_0000};
      #1;
      chk($sformatf("vec%0d_ready", k), 64'(asi_req_ready), 64'(vt[k].exp_rdy));
      chk($sformatf("vec%0d_idle_out", k), 64'(aso_resp_valid), 64'd0);
      @(negedge clk);
      asi_req_valid = '0;
      #1;
      chk($sformatf("vec%0d_grant", k), 64'(grant), 64'(vt[k].exp_gnt));
      chk($sformatf("vec%0d_orphan", k), 64'(err_orphan), 64'(vt[k].exp_orph));
      do_reset();
    end

    // Contention: three 3-word packets, served 0,1,2 with one bubble each.
    do_reset();
    for (int s = 0; s < NR; s++) push_pkt(s, 3, 32'hC000_0000 | (32'(s) << 8));
    run("contention", 100, cyc);
    chk("contention_cycles", 64'(cyc), 64'd12);

    // Fairness: source 0 back-to-back vs source 2 -> 0,2,0,2,0.
    do_reset();
    push_pkt(0, 2, 32'hF000_0000);
    push_pkt(2, 2, 32'hF200_0000);
    push_pkt(0, 2, 32'hF000_0100);
    push_pkt(2, 2, 32'hF200_0100);
    push_pkt(0, 2, 32'hF000_0200);
    run("fairness", 100, cyc);
    chk("fairness_cycles", 64'(cyc), 64'd15);

    // Backpressure on a 4-word packet from source 1.
    do_reset();
    push_pkt(1, 4, 32'h0000_00A0);
    rdyq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run("backpressure", 50, cyc);
    chk("backpressure_cycles", 64'(cyc), 64'd7);

    // Over-length: 20 words truncated to 16, last 4 drained.
    do_reset();
    push_pkt(2, 20, 32'h0000_0100);
    run("overlen", 100, cyc);
    chk("overlen_cycles", 64'(cyc), 64'd21);
    step();
    step();
    chk("overlen_pulses", 64'(ovl_cnt), 64'd1);
    chk("overlen_idle", 64'(grant), 64'd0);

    // Exactly MAX words: no truncation error, back to IDLE so next packet passes.
    do_reset();
    push_pkt(2, MAX, 32'h0000_0200);
    push_pkt(2, 1, 32'h0000_0300);
    run("exact_max", 100, cyc);
    chk("exact_max_cycles", 64'(cyc), 64'd19);
    step();
    step();
    chk("exact_max_no_err", 64'(ovl_cnt), 64'd0);

    // Orphan word dropped in IDLE, then a clean packet from the same source.
    do_reset();
    w.sop  = 1'b0;
    w.eop  = 1'b0;
    w.data = 32'h0000_DEAD;
    srcq[1].push_back(w);
    push_pkt(1, 2, 32'h0000_0B00);
    run("orphan", 50, cyc);
    step();
    chk("orphan_pulses", 64'(orph_cnt), 64'd1);
    chk("orphan_cycles", 64'(cyc), 64'd4);

    // Reset mid-packet: source 1 granted, two words out, then reset.
    do_reset();
    push_pkt(1, 4, 32'h0000_0D00);
    void'(expq.pop_back());
    void'(expq.pop_back());
    step();
    step();
    step();
    chk("midrst_words_out", 64'(expq.size()), 64'd0);
    step(1'b0);
    srcq[1].delete();
    step();
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_valid", 64'(aso_resp_valid), 64'd0);
    chk("midrst_ready", 64'(asi_req_ready), 64'd0);
    push_pkt(1, 2, 32'h0000_0E00);
    run("midrst_regrant", 50, cyc);
    chk("midrst_regrant_cycles", 64'(cyc), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
